// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
//
// Purpose: round-robin scheduler that shares one UART byte transmitter
// between four byte sources (message driver, status reporter, echo path,
// debug). One byte is handed to the transmitter at a time. The scheduler
// waits for tx_done or a baud-tick timeout, then holds an idle gap of
// GAP_TICKS baud ticks before the next grant. All logic runs on clk, in
// the transmitter's clock domain.
//
// Parameters:
//   GAP_TICKS      idle baud ticks after each frame (0 = one-cycle gap)
//   TIMEOUT_TICKS  baud ticks allowed between tx_go and tx_done (>= 1)
//
// Ports:
//   clk          system clock (divided domain), rising edge
//   rst_n        synchronous active-low reset
//   baud_tick    one-clk-wide enable at the bit rate
//   req_valid    per-requester byte-pending flags
//   req_data     requester i byte at [8i+7:8i]
//   req_ack      one-cycle pulse, byte of requester i accepted
//   tx_go        one-cycle start pulse to the transmitter
//   tx_data      byte to the transmitter, held from grant until IDLE
//   tx_done      one-cycle pulse from the transmitter at end of stop bit
//   busy         high in every state except IDLE
//   grant_id     requester currently being served
//   timeout_err  one-cycle pulse when a frame times out
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no byte in flight; arbitrate among req_valid
// START | byte latched and acked; raise tx_go for one cycle
// WAIT  | frame on the wire; wait for tx_done or timeout
// GAP   | enforced idle gap between frames

module uart_tx_scheduler #(
  parameter int GAP_TICKS     = 2,
  parameter int TIMEOUT_TICKS = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        baud_tick,
  input  logic [3:0]  req_valid,
  input  logic [31:0] req_data,
  output logic [3:0]  req_ack,
  output logic        tx_go,
  output logic [7:0]  tx_data,
  input  logic        tx_done,
  output logic        busy,
  output logic [1:0]  grant_id,
  output logic        timeout_err
);

  // One shared tick counter serves both WAIT (timeout) and GAP (idle gap),
  // so it is sized for the larger of the two limits.
  localparam int MAX_TICKS = (TIMEOUT_TICKS > GAP_TICKS) ? TIMEOUT_TICKS : GAP_TICKS;
  localparam int CW        = (MAX_TICKS < 2) ? 1 : $clog2(MAX_TICKS + 1);

  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT_TICKS);
  localparam logic [CW-1:0] GAP_C     = CW'(GAP_TICKS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t        state, state_nx;
  logic [1:0]    last_grant, last_grant_nx;
  logic [1:0]    grant_id_nx;
  logic [7:0]    tx_data_nx;
  logic [3:0]    req_ack_nx;
  logic          tx_go_nx;
  logic          timeout_err_nx;
  logic [CW-1:0] tick_cnt, tick_cnt_nx;
  logic [CW-1:0] tick_inc;

  logic [1:0]    pick;
  logic          pick_ok;
  logic [1:0]    cand;

  // Round-robin search starting just after the last grant. k=4 wraps back
  // to last_grant itself, so a lone requester can be served repeatedly.
  always_comb begin
    pick    = last_grant;
    pick_ok = 1'b0;
    cand    = '0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_grant + 2'(k);
      if (!pick_ok && req_valid[cand]) begin
        pick    = cand;
        pick_ok = 1'b1;
      end
    end
  end

  assign tick_inc = tick_cnt + CW'(1);

  always_comb begin
    state_nx       = state;
    last_grant_nx  = last_grant;
    grant_id_nx    = grant_id;
    tx_data_nx     = tx_data;
    tick_cnt_nx    = tick_cnt;
    req_ack_nx     = '0;
    tx_go_nx       = 1'b0;
    timeout_err_nx = 1'b0;

    unique case (state)
      IDLE: begin
        if (pick_ok) begin
          req_ack_nx    = 4'b0001 << pick;
          tx_data_nx    = req_data[{pick, 3'b000} +: 8];
          grant_id_nx   = pick;
          last_grant_nx = pick;
          state_nx      = START;
        end
      end

      START: begin
        tx_go_nx    = 1'b1;
        tick_cnt_nx = '0;
        state_nx    = WAIT;
      end

      WAIT: begin
        // tx_done takes priority over a coincident final timeout tick.
        if (tx_done) begin
          tick_cnt_nx = '0;
          state_nx    = GAP;
        end else if (baud_tick) begin
          if (tick_inc == TIMEOUT_C) begin
            timeout_err_nx = 1'b1;
            tick_cnt_nx    = '0;
            state_nx       = GAP;
          end else begin
            tick_cnt_nx = tick_inc;
          end
        end
      end

      GAP: begin
        if (GAP_TICKS == 0) begin
          state_nx = IDLE;
        end else if (baud_tick) begin
          if (tick_inc == GAP_C) begin
            tick_cnt_nx = '0;
            state_nx    = IDLE;
          end else begin
            tick_cnt_nx = tick_inc;
          end
        end
      end

      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_grant  <= 2'd3;
      grant_id    <= '0;
      tx_data     <= '0;
      tick_cnt    <= '0;
      req_ack     <= '0;
      tx_go       <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nx;
      last_grant  <= last_grant_nx;
      grant_id    <= grant_id_nx;
      tx_data     <= tx_data_nx;
      tick_cnt    <= tick_cnt_nx;
      req_ack     <= req_ack_nx;
      tx_go       <= tx_go_nx;
      timeout_err <= timeout_err_nx;
    end
  end

  // Derived straight from the state register so it rises with the grant
  // edge and falls on the edge that enters IDLE.
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
module tb_uart_tx_scheduler;

  localparam int GAP_TICKS     = 2;
  localparam int TIMEOUT_TICKS = 12;

  localparam int M_NORM = 0;  // tx_done done_delay cycles after tx_go
  localparam int M_TO   = 1;  // tx_done never pulses
  localparam int M_SAME = 2;  // tx_done together with 12th baud tick
  localparam int M_INJ  = 3;  // stray tx_done pulse every cycle while set

  logic        clk;
  logic        rst_n;
  logic        baud_tick;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ack;
  logic        tx_go;
  logic [7:0]  tx_data;
  logic        tx_done;
  logic        busy;
  logic [1:0]  grant_id;
  logic        timeout_err;

  uart_tx_scheduler #(
    .GAP_TICKS     (GAP_TICKS),
    .TIMEOUT_TICKS (TIMEOUT_TICKS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .baud_tick   (baud_tick),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ack     (req_ack),
    .tx_go       (tx_go),
    .tx_data     (tx_data),
    .tx_done     (tx_done),
    .busy        (busy),
    .grant_id    (grant_id),
    .timeout_err (timeout_err)
  );

  typedef struct packed {
    logic       is_to;
    logic [1:0] id;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;
  int n_acks   = 0;
  int n_to     = 0;
  int tx_mode  = M_NORM;
  int done_delay = 20;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  // Free-running baud tick: one cycle in sixteen.
  initial begin
    int bcnt;
    bcnt = 0;
    baud_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bcnt = (bcnt + 1) % 16;
      baud_tick = (bcnt == 0);
    end
  end

  // Transmitter model, updates at posedge+2 after baud_tick has settled.
  initial begin
    int active, wcnt, tcnt;
    active = 0; wcnt = 0; tcnt = 0;
    tx_done = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      tx_done = 1'b0;
      if (!rst_n) begin
        active = 0;
      end else if (tx_mode == M_INJ) begin
        tx_done = 1'b1;
      end else if (active != 0) begin
        if (tx_mode == M_NORM) begin
          wcnt = wcnt - 1;
          if (wcnt == 0) begin tx_done = 1'b1; active = 0; end
        end else if (tx_mode == M_SAME) begin
          if (baud_tick) tcnt++;
          if (tcnt == TIMEOUT_TICKS) begin tx_done = 1'b1; active = 0; end
        end
      end
      if (rst_n && tx_go) begin
        active = 1;
        wcnt   = done_delay - 1;
        tcnt   = baud_tick ? 1 : 0;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT acks or times out, and
  // tracks tx_go latency, timeout tick count and gap length.
  initial begin
    bit in_wait, gap_on, ack_prev, busy_prev;
    int ticks, gap_cnt;
    exp_t e;
    in_wait = 0; gap_on = 0; ack_prev = 0; busy_prev = 0;
    ticks = 0; gap_cnt = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_wait = 0; gap_on = 0; ack_prev = 0; busy_prev = 0;
        ticks = 0; gap_cnt = 0;
      end else begin
        if (ack_prev || tx_go) chk("tx_go_latency", int'(tx_go), int'(ack_prev));
        if (req_ack != 4'b0000) begin
          n_acks++;
          if (sb.size() == 0) begin
            chk("unexpected_ack", int'(req_ack), 0);
          end else begin
            e = sb.pop_front();
            chk("ack_kind", int'(e.is_to), 0);
            chk("ack_onehot", int'(req_ack), int'(4'b0001 << e.id));
            chk("grant_id", int'(grant_id), int'(e.id));
            chk("tx_data", int'(tx_data), int'(e.data));
            chk("busy_on_ack", int'(busy), 1);
          end
        end
        if (timeout_err) begin
          n_to++;
          if (sb.size() == 0) begin
            chk("unexpected_timeout", int'(timeout_err), 0);
          end else begin
            e = sb.pop_front();
            chk("timeout_kind", int'(e.is_to), 1);
          end
          chk("timeout_ticks", ticks, TIMEOUT_TICKS);
        end
        if (busy_prev && !busy) begin
          chk("gap_ticks", gap_cnt, GAP_TICKS);
          gap_on = 0;
        end
        if (timeout_err) begin
          in_wait = 0; gap_on = 1; gap_cnt = 0;
        end
        if (gap_on) gap_cnt += int'(baud_tick);
        if (in_wait && tx_done) begin
          in_wait = 0; gap_on = 1; gap_cnt = 0;
        end
        if (tx_go) begin
          in_wait = 1;
          ticks = int'(baud_tick);
        end else begin
          ticks += int'(baud_tick);
        end
        ack_prev  = (req_ack != 4'b0000);
        busy_prev = busy;
      end
    end
  end

  // Requesters drop the acked byte right after the ack edge.
  task automatic tick_cycle();
    @(posedge clk);
    #1;
    req_valid = req_valid & ~req_ack;
  endtask

  task automatic push_ack(input logic [1:0] id, input logic [7:0] d);
    exp_t e;
    e.is_to = 1'b0; e.id = id; e.data = d;
    sb.push_back(e);
  endtask

  task automatic push_to();
    exp_t e;
    e.is_to = 1'b1; e.id = 2'd0; e.data = 8'h00;
    sb.push_back(e);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n;
    n = 0;
    while ((sb.size() != 0 || busy || req_valid != 4'b0000) && n < budget) begin
      tick_cycle();
      n++;
    end
    chk({tag, "_reached_idle"}, int'(n < budget), 1);
  endtask

  task automatic wait_acks(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (n_acks < target && n < budget) begin
      tick_cycle();
      n++;
    end
    chk({tag, "_ack_seen"}, int'(n < budget), 1);
  endtask

  task automatic wait_tos(input int target, input int budget, input string tag);
    int n;
    n = 0;
    while (n_to < target && n < budget) begin
      tick_cycle();
      n++;
    end
    chk({tag, "_timeout_seen"}, int'(n < budget), 1);
  endtask

  task automatic check_outputs_zero(input string tag);
    chk({tag, "_req_ack"},     int'(req_ack), 0);
    chk({tag, "_tx_go"},       int'(tx_go), 0);
    chk({tag, "_tx_data"},     int'(tx_data), 0);
    chk({tag, "_busy"},        int'(busy), 0);
    chk({tag, "_grant_id"},    int'(grant_id), 0);
    chk({tag, "_timeout_err"}, int'(timeout_err), 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 4'b0000;
    req_data  = 32'h0;
    repeat (3) tick_cycle();
    check_outputs_zero("reset");
    rst_n = 1'b1;
    repeat (2) tick_cycle();

    // All four at once: served 0,1,2,3 from reset priority.
    tx_mode = M_NORM; done_delay = 20;
    req_data = 32'h64636261;
    push_ack(2'd0, 8'h61); push_ack(2'd1, 8'h62);
    push_ack(2'd2, 8'h63); push_ack(2'd3, 8'h64);
    req_valid = 4'b1111;
    wait_idle(2000, "all_four");

    // Single requester, long frame.
    done_delay = 100;
    req_data[7:0] = 8'h76;
    push_ack(2'd0, 8'h76);
    req_valid = 4'b0001;
    wait_idle(2000, "single");

    // Fairness: after grant 2, requesters 3 and 0 -> 3 then 0.
    done_delay = 20;
    req_data[23:16] = 8'hA2;
    push_ack(2'd2, 8'hA2);
    req_valid = 4'b0100;
    wait_acks(n_acks + 1, 200, "fair_first");
    req_data[31:24] = 8'hD3;
    req_data[7:0]   = 8'hD0;
    push_ack(2'd3, 8'hD3); push_ack(2'd0, 8'hD0);
    req_valid = req_valid | 4'b1001;
    wait_idle(2000, "fairness");

    // Timeout on requester 1, then requester 2 served normally.
    tx_mode = M_TO;
    req_data[15:8]  = 8'h5A;
    req_data[23:16] = 8'hA5;
    push_ack(2'd1, 8'h5A); push_to(); push_ack(2'd2, 8'hA5);
    req_valid = 4'b0110;
    wait_tos(1, 500, "timeout");
    tx_mode = M_NORM; done_delay = 20;
    wait_idle(2000, "timeout_recover");

    // tx_done coincides with the 12th tick: no timeout.
    tx_mode = M_SAME;
    req_data[31:24] = 8'h3C;
    push_ack(2'd3, 8'h3C);
    req_valid = 4'b1000;
    wait_idle(2000, "same_cycle");

    // Reset in the middle of WAIT.
    tx_mode = M_TO;
    req_data[15:8] = 8'h11;
    push_ack(2'd1, 8'h11);
    req_valid = 4'b0010;
    wait_acks(n_acks + 1, 200, "rst_mid");
    repeat (10) tick_cycle();
    rst_n = 1'b0;
    tick_cycle();
    check_outputs_zero("mid_reset");
    rst_n = 1'b1;
    tx_mode = M_INJ;
    tick_cycle();
    tx_mode = M_TO;
    repeat (5) tick_cycle();
    chk("stray_done_busy", int'(busy), 0);
    chk("stray_done_go", int'(tx_go), 0);

    // Priority restarts at requester 0 after reset.
    tx_mode = M_NORM; done_delay = 20;
    req_data[7:0]   = 8'h44;
    req_data[31:24] = 8'h99;
    push_ack(2'd0, 8'h44); push_ack(2'd3, 8'h99);
    req_valid = 4'b1001;
    wait_idle(2000, "post_reset");

    repeat (4) tick_cycle();
    chk("sb_empty", sb.size(), 0);
    chk("ack_total", n_acks, 14);
    chk("timeout_total", n_to, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Round-robin scheduler that shares the single UART byte transmitter between four independent byte sources (message driver, status reporter, echo path, debug). It sits between the requesters and the tx module. It runs on the divided clock, in the same domain as the tx module. It hands one byte at a time to the transmitter, waits for completion or timeout, and enforces an idle gap between frames.

## Interface
Parameters:
- GAP_TICKS, 2, idle baud ticks inserted after each frame (0 = no gap)
- TIMEOUT_TICKS, 12, baud ticks allowed between tx_go and tx_done before abort

Ports:
- clk  in  1  system clock (divided clock domain); all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- baud_tick  in  1  one-clk-wide enable at bit rate
- req_valid  in  4  requester i has a byte pending
- req_data  in  32  byte for requester i at [8i+7:8i]
- req_ack  out  4  one-cycle pulse: byte of requester i accepted
- tx_go  out  1  one-cycle start pulse to transmitter
- tx_data  out  8  byte to transmitter; held stable from grant until return to IDLE
- tx_done  in  1  one-cycle pulse from transmitter at end of stop bit
- busy  out  1  high in every state except IDLE
- grant_id  out  2  index of the requester currently being served
- timeout_err  out  1  one-cycle pulse on transmit timeout

## Operation
- States: IDLE, START, WAIT, GAP.
- IDLE, any req_valid high: pick the first requester with req_valid high, searching from (last_grant+1) mod 4 upward with wrap. Latch its byte into tx_data. Set grant_id and last_grant to it. Pulse req_ack[i]. Go to START.
- START: assert tx_go for exactly one cycle, clear tick counter, go to WAIT.
- WAIT:
  - tx_done high: go to GAP.
  - Otherwise count baud_tick. When the count reaches TIMEOUT_TICKS, pulse timeout_err and go to GAP.
  - If tx_done and the final timeout tick occur in the same cycle, tx_done wins and there is no error.
- GAP: count baud_tick. After GAP_TICKS ticks, go to IDLE. With GAP_TICKS=0, GAP lasts one cycle, then IDLE.
- tx_done outside WAIT is ignored.
- req_valid and req_data are sampled only in IDLE. Changes in other states have no effect.
- Ack semantics:
  - req_ack consumes exactly one byte.
  - The requester must update req_data or drop req_valid in the cycle after ack.
  - A req_valid still high in the next IDLE is a new byte.
- Only one req_ack bit is ever high. At most one byte is in flight.
- Reset:
  - Outputs: req_ack=0, tx_go=0, tx_data=0, busy=0, grant_id=0, timeout_err=0.
  - Internal: state=IDLE, last_grant=3 (requester 0 has first priority), counters=0.
- Reset mid-operation drops tx_go and busy at the reset edge. The in-flight byte is abandoned and gets no re-ack.

## Timing
- Request latency: req_valid high and sampled at edge k in IDLE. At edge k, req_ack, tx_data, grant_id and busy update. At edge k+1, tx_go=1. At edge k+2, tx_go=0.
- Minimum spacing between consecutive req_acks:
  - 3 cycles + frame time + GAP_TICKS baud ticks.
  - With GAP_TICKS=0, IDLE is reached one cycle after GAP entry and a new grant can occur the following edge.
- busy falls on the edge entering IDLE.
- timeout_err is asserted on the edge that leaves WAIT.
- Baud ticks coinciding with a state-entry edge are not counted in the new state.

## Test plan
- Single requester: req_valid=4'b0001, req_data[7:0]=8'h76; tx_done 100 cycles after tx_go.
  -> req_ack=0001 once; tx_data=8'h76; tx_go one cycle, one edge after ack; busy high until GAP_TICKS=2 ticks after tx_done.
- All four request simultaneously with bytes 8'h61/62/63/64; each held until acked.
  -> grants in order 0,1,2,3; tx_data sequence 61,62,63,64; exactly one ack each.
- Fairness: after grant 2, req_valid=4'b1001.
  -> next grant 3, then 0.
- Timeout: grant issued, tx_done never pulses.
  -> timeout_err pulses on the 12th baud_tick after tx_go; GAP, then IDLE; the next pending requester is served.
- Same-cycle tx_done and 12th tick.
  -> no timeout_err; normal GAP.
- Reset mid-WAIT with rst_n low for 1 cycle.
  -> all outputs 0 at the reset edge; later tx_done ignored; next request granted to requester 0 first.
